// File: rtl/bit_stream_lock.sv
// bit_stream_lock: serial frame-sync lock detector.
// Hunts a 1-bit stream for SYNC_WORD, locks after LOCK_HITS matches spaced
// FRAME_LEN bits apart, and unlocks after MISS_LIMIT consecutive missed
// sync words while locked.
// Optional build macro: BIT_STREAM_LOCK_STATE_OUT_EN adds a state[3:0]
// output carrying the current state encoding.
module bit_stream_lock #(
  parameter int                SYNC_W     = 4,
  parameter logic [SYNC_W-1:0] SYNC_WORD  = 4'b1011,
  parameter int                FRAME_LEN  = 8,
  parameter int                LOCK_HITS  = 2,
  parameter int                MISS_LIMIT = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       din,
  input  logic       en,
  output logic       lock
`ifdef BIT_STREAM_LOCK_STATE_OUT_EN
  ,
  output logic [3:0] state
`endif
);

  localparam int CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int HIT_W  = $clog2(LOCK_HITS + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [3:0] S_HUNT   = 4'd0;
  localparam logic [3:0] S_VERIFY = 4'd1;
  localparam logic [3:0] S_LOCKED = 4'd2;

  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [HIT_W-1:0]  HITS_NEED  = HIT_W'(LOCK_HITS);
  localparam logic [MISS_W-1:0] MISS_NEED  = MISS_W'(MISS_LIMIT);

  // Only the oldest SYNC_W-1 bits are stored; the newest bit is din itself,
  // so the full SYNC_W window is {r_sh, din} on every sampled bit.
  logic [SYNC_W-2:0] r_sh;
  logic [3:0]        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [HIT_W-1:0]  r_hits;
  logic [MISS_W-1:0] r_misses;
  logic              r_lock;

  logic [SYNC_W-1:0] w_sh_next;
  logic              w_match;
  logic              w_boundary;
  logic [3:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [HIT_W-1:0]  w_hits_nxt;
  logic [MISS_W-1:0] w_misses_nxt;
  logic [HIT_W-1:0]  w_hits_inc;
  logic [MISS_W-1:0] w_misses_inc;

  assign w_sh_next    = {r_sh, din};
  assign w_match      = (w_sh_next == SYNC_WORD);
  assign w_boundary   = (r_bit_cnt == FRAME_LAST);
  assign w_hits_inc   = r_hits + 1'b1;
  assign w_misses_inc = r_misses + 1'b1;

  // Next-state and counter decisions for one sampled bit.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_bit_cnt;
    w_hits_nxt   = r_hits;
    w_misses_nxt = r_misses;
    case (r_state)
      S_HUNT: begin
        if (w_match) begin
          w_cnt_nxt   = '0;
          w_hits_nxt  = HIT_W'(1);
          w_state_nxt = (LOCK_HITS == 1) ? S_LOCKED : S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          if (w_match) begin
            w_hits_nxt = w_hits_inc;
            if (w_hits_inc == HITS_NEED) begin
              w_state_nxt = S_LOCKED;
            end
          end else begin
            // The failing boundary bit is not re-examined as a new start.
            w_hits_nxt  = '0;
            w_state_nxt = S_HUNT;
          end
        end else begin
          w_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      S_LOCKED: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          if (w_match) begin
            w_misses_nxt = '0;
          end else if (w_misses_inc == MISS_NEED) begin
            w_misses_nxt = '0;
            w_hits_nxt   = '0;
            w_state_nxt  = S_HUNT;
          end else begin
            w_misses_nxt = w_misses_inc;
          end
        end else begin
          w_cnt_nxt = r_bit_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_HUNT;
      end
    endcase
  end

  // Register update: reset wins, otherwise advance only on valid bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh      <= '0;
      r_state   <= S_HUNT;
      r_bit_cnt <= '0;
      r_hits    <= '0;
      r_misses  <= '0;
      r_lock    <= 1'b0;
    end else if (en) begin
      r_sh      <= w_sh_next[SYNC_W-2:0];
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_cnt_nxt;
      r_hits    <= w_hits_nxt;
      r_misses  <= w_misses_nxt;
      r_lock    <= (w_state_nxt == S_LOCKED);
    end
  end

  assign lock = r_lock;

`ifdef BIT_STREAM_LOCK_STATE_OUT_EN
  assign state = r_state;
`endif

endmodule

// File: tb/tb_bit_stream_lock.sv
// Directed bench for bit_stream_lock with default parameters.
module tb_bit_stream_lock;

  logic clk;
  logic rst_n;
  logic din;
  logic en;
  logic lock;
`ifdef BIT_STREAM_LOCK_STATE_OUT_EN
  logic [3:0] state;
`endif

  int total = 0;
  int bad   = 0;

  bit_stream_lock dut (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .en    (en),
    .lock  (lock)
`ifdef BIT_STREAM_LOCK_STATE_OUT_EN
    ,
    .state (state)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic exp);
    total++;
    assert (lock === exp) else begin
      bad++;
      $error("FAIL %s: lock=%0b expected=%0b", tag, lock, exp);
    end
  endtask

  // One clock with the given inputs; inputs change on negedge, lock is
  // sampled 1ns after the posedge.
  task automatic tick(input logic r, input logic e, input logic d);
    @(negedge clk);
    rst_n = r;
    en    = e;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  // Sends n bits of pat MSB-first, checking lock after each bit against
  // the matching MSB-first bit of exp. gap idle (en=0) clocks follow each
  // bit, during which lock must hold its value.
  task automatic send(input string tag, input logic [7:0] pat, input int n,
                      input logic [7:0] exp, input int gap);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b1, pat[7-i]);
      chk($sformatf("%s.b%0d", tag, i), exp[7-i]);
      for (int g = 0; g < gap; g++) begin
        tick(1'b1, 1'b0, ~pat[7-i]);
        chk($sformatf("%s.b%0d.idle%0d", tag, i, g), exp[7-i]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    din   = 1'b0;

    // 1. Reset with din toggling, then release with din=0.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, i[0]);
      chk($sformatf("rst.hold%0d", i), 1'b0);
    end
    tick(1'b1, 1'b1, 1'b0);
    chk("rst.rel0", 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("rst.rel1", 1'b0);

    // 2. Acquire: lock rises on bit 12.
    send("acq.f1", 8'b1011_0000, 8, 8'b0000_0000, 0);
    send("acq.f2", 8'b1011_0000, 8, 8'b0001_1111, 0);

    // 3. Loss: first miss tolerated, second drops lock.
    send("loss.f1", 8'b0000_0000, 8, 8'b1111_1111, 0);
    send("loss.f2", 8'b0000_0000, 8, 8'b1110_0000, 0);

    // 4. Single miss tolerance; a match clears the miss count.
    send("tol.a1", 8'b1011_0000, 8, 8'b0000_0000, 0);
    send("tol.a2", 8'b1011_0000, 8, 8'b0001_1111, 0);
    send("tol.m1", 8'b0000_0000, 8, 8'b1111_1111, 0);
    send("tol.ok", 8'b1011_0000, 8, 8'b1111_1111, 0);
    send("tol.m2", 8'b0000_0000, 8, 8'b1111_1111, 0);
    send("tol.m3", 8'b0000_0000, 8, 8'b1110_0000, 0);

    // 5. False start: 1111 at the boundary returns to HUNT.
    send("fs.f1",  8'b1011_0000, 8, 8'b0000_0000, 0);
    send("fs.bad", 8'b1111_0000, 4, 8'b0000_0000, 0);
    send("fs.r1",  8'b1011_0000, 8, 8'b0000_0000, 0);
    send("fs.r2",  8'b1011_0000, 4, 8'b0001_0000, 0);

    // 6a. Mid-op reset while locked; re-acquire needs two matches.
    tick(1'b0, 1'b1, 1'b1);
    chk("mid.rst", 1'b0);
    send("mid.f1", 8'b1011_0000, 8, 8'b0000_0000, 0);
    send("mid.f2", 8'b1011_0000, 4, 8'b0001_0000, 0);

    // 6b. Acquire with 3 idle clocks between bits: same lock bit index.
    tick(1'b0, 1'b0, 1'b0);
    chk("gap.rst", 1'b0);
    send("gap.f1", 8'b1011_0000, 8, 8'b0000_0000, 3);
    send("gap.f2", 8'b1011_0000, 8, 8'b0001_1111, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
